// File: rtl/digit_serial_comparator.sv
// rtl/digit_serial_comparator.sv - MSB-first digit-serial magnitude comparator
// Resolves a vs b DIGIT bits per clock, stopping at the first differing digit.
module digit_serial_comparator #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4,
    localparam int NDIG = WIDTH / DIGIT,
    localparam int CW   = $clog2(NDIG + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CW-1:0]    cycles
);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("DIGIT must be in 1..WIDTH and divide WIDTH evenly");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;
    logic [CW-1:0]    r_cycles;

    logic [WIDTH-1:0] w_flip;
    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign w_flip   = WIDTH'(signed_mode) << (WIDTH - 1);
    assign w_da     = r_a[WIDTH-1 -: DIGIT];
    assign w_db     = r_b[WIDTH-1 -: DIGIT];
    assign in_ready = (r_state == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_gt        <= 1'b0;
            r_eq        <= 1'b0;
            r_lt        <= 1'b0;
            r_cycles    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a ^ w_flip;
                        r_b     <= b ^ w_flip;
                        r_cnt   <= '0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_da != w_db) begin
                        r_gt        <= (w_da > w_db);
                        r_lt        <= (w_da < w_db);
                        r_eq        <= 1'b0;
                        r_cycles    <= r_cnt + CW'(1);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_cnt == CW'(NDIG - 1)) begin
                        r_gt        <= 1'b0;
                        r_lt        <= 1'b0;
                        r_eq        <= 1'b1;
                        r_cycles    <= CW'(NDIG);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_a   <= r_a << DIGIT;
                        r_b   <= r_b << DIGIT;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign gt        = r_gt;
    assign eq        = r_eq;
    assign lt        = r_lt;
    assign cycles    = r_cycles;

endmodule

// File: tb/tb_digit_serial_comparator.sv
// tb/tb_digit_serial_comparator.sv - self-checking bench for digit_serial_comparator
// Instance 0 (DIGIT=4) takes directed vectors; instances 1..3 sweep DIGIT=1/8/32.
module tb_digit_serial_comparator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Reference: plain signed/unsigned compare; cycles from the highest differing bit.
    function automatic void ref_cmp(input logic [31:0] av, input logic [31:0] bv, input logic smv,
                                    input int dg, output logic rgt, output logic req,
                                    output logic rlt, output int rcyc);
        logic [31:0] x;
        if (smv) begin
            rgt = $signed(av) > $signed(bv);
            rlt = $signed(av) < $signed(bv);
        end else begin
            rgt = av > bv;
            rlt = av < bv;
        end
        req  = (av == bv);
        x    = av ^ bv;
        rcyc = 32 / dg;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) rcyc = (31 - i) / dg + 1;
        end
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_blk
        localparam int DG  = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 32;
        localparam int ND  = 32 / DG;
        localparam int CWG = $clog2(ND + 1);

        logic           rst       = 1'b1;
        logic           in_valid  = 1'b0;
        logic           sm        = 1'b0;
        logic           out_ready = 1'b0;
        logic [31:0]    a         = '0;
        logic [31:0]    b         = '0;
        logic           in_ready;
        logic           out_valid;
        logic           gt;
        logic           eq;
        logic           lt;
        logic [CWG-1:0] cycles;
        bit             mon_en    = 1'b0;
        bit             done      = 1'b0;

        digit_serial_comparator #(.WIDTH(32), .DIGIT(DG)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (in_valid),
            .in_ready    (in_ready),
            .a           (a),
            .b           (b),
            .signed_mode (sm),
            .out_valid   (out_valid),
            .out_ready   (out_ready),
            .gt          (gt),
            .eq          (eq),
            .lt          (lt),
            .cycles      (cycles)
        );

        initial begin
            @(posedge clk);
            #1;
            mon_en = 1'b1;
        end

        // Transaction-level model: result appears `cycles` edges after accept.
        logic m_busy  = 1'b0;
        logic m_valid = 1'b0;
        int   m_timer = 0;
        logic m_gt = 1'b0, m_eq = 1'b0, m_lt = 1'b0;
        int   m_cyc = 0;
        logic p_gt, p_eq, p_lt;
        int   p_cyc;

        always @(negedge clk) begin
            if (mon_en) begin
                check($sformatf("d%0d.out_valid", DG), out_valid, m_valid);
                check($sformatf("d%0d.in_ready", DG), in_ready, !rst && !m_busy && !m_valid);
                check($sformatf("d%0d.gt", DG), gt, m_gt);
                check($sformatf("d%0d.eq", DG), eq, m_eq);
                check($sformatf("d%0d.lt", DG), lt, m_lt);
                check($sformatf("d%0d.cycles", DG), cycles, m_cyc);
                if (rst) begin
                    m_busy  = 1'b0;
                    m_valid = 1'b0;
                    m_gt    = 1'b0;
                    m_eq    = 1'b0;
                    m_lt    = 1'b0;
                    m_cyc   = 0;
                end else if (m_valid) begin
                    if (out_ready) m_valid = 1'b0;
                end else if (m_busy) begin
                    m_timer--;
                    if (m_timer == 0) begin
                        m_busy  = 1'b0;
                        m_valid = 1'b1;
                        m_gt    = p_gt;
                        m_eq    = p_eq;
                        m_lt    = p_lt;
                        m_cyc   = p_cyc;
                    end
                end else if (in_valid) begin
                    ref_cmp(a, b, sm, DG, p_gt, p_eq, p_lt, p_cyc);
                    m_timer = p_cyc;
                    m_busy  = 1'b1;
                end
            end
        end

        if (g > 0) begin : g_rnd
            initial begin
                int k;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                for (int n = 0; n < 1000; n++) begin
                    a = $urandom;
                    b = $urandom;
                    case ($urandom_range(0, 3))
                        0: b = a;
                        1: b = a ^ (32'h1 << $urandom_range(0, 31));
                        default: ;
                    endcase
                    sm       = 1'($urandom_range(0, 1));
                    in_valid = 1'b1;
                    k = 0;
                    while (!in_ready && k < 100) begin
                        @(posedge clk);
                        #1;
                        k++;
                    end
                    @(posedge clk);
                    #1;
                    in_valid = 1'b0;
                    k = 0;
                    while (!out_valid && k < 100) begin
                        @(posedge clk);
                        #1;
                        k++;
                    end
                    check($sformatf("d%0d.result_timeout", DG), k < 100, 1'b1);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    out_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    out_ready = 1'b0;
                end
                done = 1'b1;
            end
        end
    end

    task automatic d_send(input logic [31:0] av, input logic [31:0] bv, input logic smv);
        int k;
        g_blk[0].a        = av;
        g_blk[0].b        = bv;
        g_blk[0].sm       = smv;
        g_blk[0].in_valid = 1'b1;
        k = 0;
        while (!g_blk[0].in_ready && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("accept_timeout", k < 50, 1'b1);
        @(posedge clk);
        #1;
        g_blk[0].in_valid = 1'b0;
    endtask

    task automatic d_result(input string name, input logic eg, input logic ee, input logic el, input int ec);
        int lat;
        lat = 0;
        while (!g_blk[0].out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, ".latency"}, lat, ec);
        check({name, ".gt"}, g_blk[0].gt, eg);
        check({name, ".eq"}, g_blk[0].eq, ee);
        check({name, ".lt"}, g_blk[0].lt, el);
        check({name, ".cycles"}, g_blk[0].cycles, ec);
        g_blk[0].out_ready = 1'b1;
        @(posedge clk);
        #1;
        g_blk[0].out_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid", g_blk[0].out_valid, 1'b0);
        check("reset.gt", g_blk[0].gt, 1'b0);
        check("reset.eq", g_blk[0].eq, 1'b0);
        check("reset.lt", g_blk[0].lt, 1'b0);
        check("reset.cycles", g_blk[0].cycles, 0);
        check("reset.in_ready_held", g_blk[0].in_ready, 1'b0);
        g_blk[0].rst = 1'b0;
        #1;
        check("reset.in_ready_release", g_blk[0].in_ready, 1'b1);

        d_send(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        d_result("u_msb", 1'b1, 1'b0, 1'b0, 1);
        d_send(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        d_result("s_msb", 1'b0, 1'b0, 1'b1, 1);
        d_send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        d_result("s_neg1", 1'b0, 1'b0, 1'b1, 1);
        d_send(32'h1234_5678, 32'h1234_5678, 1'b0);
        d_result("equal", 1'b0, 1'b1, 1'b0, 8);
        d_send(32'h0000_0001, 32'h0000_0000, 1'b0);
        d_result("lsb_gt", 1'b1, 1'b0, 1'b0, 8);
        d_send(32'h0000_0010, 32'h0000_0020, 1'b0);
        d_result("nib6_lt", 1'b0, 1'b0, 1'b1, 7);
        d_send(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        d_result("s_m1_m2", 1'b1, 1'b0, 1'b0, 8);

        // Backpressure: result held, new operands ignored while DONE.
        d_send(32'hF000_0000, 32'h0000_0000, 1'b0);
        k = 0;
        while (!g_blk[0].out_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("bp.latency", k, 1);
        g_blk[0].a        = 32'h0;
        g_blk[0].b        = 32'hFFFF_FFFF;
        g_blk[0].in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp.out_valid", g_blk[0].out_valid, 1'b1);
            check("bp.gt", g_blk[0].gt, 1'b1);
            check("bp.cycles", g_blk[0].cycles, 1);
            check("bp.in_ready", g_blk[0].in_ready, 1'b0);
        end
        g_blk[0].in_valid  = 1'b0;
        g_blk[0].out_ready = 1'b1;
        @(posedge clk);
        #1;
        g_blk[0].out_ready = 1'b0;
        check("bp.drop_valid", g_blk[0].out_valid, 1'b0);
        check("bp.idle_ready", g_blk[0].in_ready, 1'b1);
        check("bp.hold_gt", g_blk[0].gt, 1'b1);

        // Reset during the 4th SCAN cycle aborts the transaction.
        d_send(32'h1234_5678, 32'h1234_5678, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        g_blk[0].rst = 1'b1;
        @(posedge clk);
        #1;
        g_blk[0].rst = 1'b0;
        check("rst_scan.gt", g_blk[0].gt, 1'b0);
        check("rst_scan.cycles", g_blk[0].cycles, 0);
        k = 0;
        for (int i = 0; i < 12; i++) begin
            if (g_blk[0].out_valid) k++;
            @(posedge clk);
            #1;
        end
        check("rst_scan.no_valid", k, 0);
        d_send(32'h0000_0005, 32'h0000_0009, 1'b0);
        d_result("after_rst", 1'b0, 1'b0, 1'b1, 8);

        k = 0;
        while (!(g_blk[1].done && g_blk[2].done && g_blk[3].done) && k < 80000) begin
            @(posedge clk);
            k++;
        end
        check("sweep_timeout", k < 80000, 1'b1);
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
